instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, program word count; power of two, >= 2; AW = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_en  input  1  program-word write strobe.
REQ-006 SHALL have port load_addr  input  AW  program write address.
REQ-007 SHALL have port load_data  input  5+2*WIDTH  instruction: [2:0] op, [3] use_prev, [4] halt, [4+WIDTH:5] imm_b, [4+2*WIDTH:5+WIDTH] imm_a.
REQ-008 SHALL have port start  input  1  begin execution at address 0.
REQ-009 SHALL have ports issue_valid out 1, issue_ready in 1, issue_op out 3, issue_a out WIDTH, issue_b out WIDTH  operand issue to the ALU stage.
REQ-010 SHALL have ports res_valid in 1, res_data in WIDTH  result returned by the ALU stage.
REQ-011 SHALL have ports busy out 1, done out 1, err out 1, pc out AW  status.

Function
REQ-012 SHALL hold a DEPTH x (5+2*WIDTH) program memory, written on a clock edge when load_en=1 and state is IDLE or DONE; writes in other states are ignored.
REQ-013 SHALL implement states IDLE, FETCH, ISSUE, WAIT_RES, DONE.
REQ-014 IDLE or DONE: start=1 -> pc<=0, FETCH; start in any other state is ignored.
REQ-015 FETCH: register word[pc] into issue_op/a/b; issue_a = prev_result when use_prev=1, else imm_a; set issue_valid=1; go to ISSUE.
REQ-016 A load_en write and start on the same edge SHALL both take effect; the FETCH one cycle later sees the new word.
REQ-017 ISSUE: issue_valid=1, and payload stays stable until an edge with issue_ready=1; on that edge issue_valid<=0 and the state goes to WAIT_RES.
REQ-018 WAIT_RES: on an edge with res_valid=1, prev_result<=res_data; then go to DONE if halt=1 or pc=DEPTH-1, else pc<=pc+1 and go to FETCH.
REQ-019 res_valid outside WAIT_RES SHALL be ignored; pc SHALL never wrap.
REQ-020 Latency: start sampled at edge k -> issue_valid=1 after edge k+1; result accepted at edge m -> next issue_valid=1 after edge m+1.
REQ-021 busy=1 in FETCH, ISSUE and WAIT_RES; done=1 only in DONE (registered); pc shows the current instruction address.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE, pc 0, prev_result 0, issue_valid 0, issue_op/a/b 0, busy 0, done 0, err 0.
REQ-023 Reset mid-operation SHALL abort the program with no further issue; program memory is not reset and keeps its contents.

Configuration
REQ-024 With macro SEQ_TIMEOUT_EN defined: a 4-bit counter runs in WAIT_RES; on the 16th consecutive WAIT_RES cycle without res_valid, err<=1 and the state goes to DONE; err clears on start or reset.
REQ-025 Without SEQ_TIMEOUT_EN: WAIT_RES waits indefinitely and err is tied to 0.

Verification
REQ-026 Program {op0 a10 b5}, {op1 use_prev b3}, {op2 use_prev b15 halt}; model returns 15, 12, 12 -> issues (0,10,5), (1,15,3), (2,12,15); done=1 after the third result.
REQ-027 Hold issue_ready=0 for 3 cycles in ISSUE -> issue_valid and payload unchanged; a single transfer when ready=1.
REQ-028 DEPTH=4, no halt bits, ALU returns each result -> 4 issues, pc 0..3, done with pc=3, no wrap.
REQ-029 Assert rst_n=0 during WAIT_RES of instr 1 -> outputs at reset values at once; after rst_n=1 and start, execution restarts at pc 0 with the memory intact.
REQ-030 Assert start and load_en during busy -> both ignored; with SEQ_TIMEOUT_EN and res_valid withheld -> err=1, done=1 after 16 WAIT_RES cycles.

Source files
------------

// File: rtl/instr_sequencer.sv
// Micro-program sequencer: fetches words from a small program RAM and issues operands to an ALU stage.
// Optional SEQ_TIMEOUT_EN flags a stalled ALU result after 16 waiting cycles and aborts to DONE with err set.
module instr_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = 5 + 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IW-1:0]    load_data,
    input  logic             start,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [2:0]       issue_op,
    output logic [WIDTH-1:0] issue_a,
    output logic [WIDTH-1:0] issue_b,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    pc
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_pc;
    logic [WIDTH-1:0] r_prev;
    logic             r_halt;
    logic             r_issue_valid;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;

    logic [IW-1:0]    w_word;
    logic [2:0]       w_op;
    logic             w_use_prev;
    logic             w_halt;
    logic [WIDTH-1:0] w_imm_a;
    logic [WIDTH-1:0] w_imm_b;
    logic             w_load_ok;
    logic             w_last;

    assign w_word     = r_mem[r_pc];
    assign w_op       = w_word[2:0];
    assign w_use_prev = w_word[3];
    assign w_halt     = w_word[4];
    assign w_imm_b    = w_word[4+WIDTH:5];
    assign w_imm_a    = w_word[4+2*WIDTH:5+WIDTH];
    assign w_load_ok  = (r_state == S_IDLE) || (r_state == S_DONE);
    // The final instruction ends the program rather than letting pc wrap to 0.
    assign w_last     = r_halt || (r_pc == AW'(DEPTH - 1));

    // Program RAM survives reset so a program can be rerun after an abort.
    always_ff @(posedge clk) begin
        if (load_en && w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [3:0] r_tmo;
    logic       r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_prev        <= '0;
            r_halt        <= 1'b0;
            r_issue_valid <= 1'b0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_tmo         <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_FETCH;
`ifdef SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    r_op          <= w_op;
                    r_a           <= w_use_prev ? r_prev : w_imm_a;
                    r_b           <= w_imm_b;
                    r_halt        <= w_halt;
                    r_issue_valid <= 1'b1;
                    r_state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        r_issue_valid <= 1'b0;
                        r_state       <= S_WAIT_RES;
`ifdef SEQ_TIMEOUT_EN
                        r_tmo         <= '0;
`endif
                    end
                end
                S_WAIT_RES: begin
                    if (res_valid) begin
                        r_prev <= res_data;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pc    <= r_pc + AW'(1);
                            r_state <= S_FETCH;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    // Counter saturating at 15 marks the 16th silent cycle.
                    else if (r_tmo == 4'hF) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 4'd1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_op    = r_op;
    assign issue_a     = r_a;
    assign issue_b     = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pc          = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a program-level model predicts every issued operand set and status.
// Covers the SEQ_TIMEOUT_EN build and the default build.
module tb_instr_sequencer;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int AW = $clog2(D);
    localparam int IW = 5 + 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          start;
    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    issue_op;
    logic [W-1:0]  issue_a;
    logic [W-1:0]  issue_b;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] pc;

    instr_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .done(done), .err(err), .pc(pc)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] prog [D];
    logic [W-1:0]  m_prev;
    int            n_total = 0;
    int            n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return b;
            default: return a;
        endcase
    endfunction

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic use_prev, input logic halt,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
        return {a, b, halt, use_prev, op};
    endfunction

    task automatic load_word(input int addr, input logic [IW-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        prog[addr] = data;
        step();
        load_en = 1'b0;
    endtask

    task automatic load_random(input int halt_odds);
        logic [IW-1:0] w;
        for (int k = 0; k < D; k++) begin
            w = IW'($urandom);
            w[4] = (halt_odds > 0) && ($urandom_range(0, halt_odds - 1) == 0);
            load_word(k, w);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iv"},   32'(issue_valid), 32'd0);
        chk({tag, "_pay"},  32'({issue_op, issue_a, issue_b}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"},  32'(err), 32'd0);
        chk({tag, "_pc"},   32'(pc), 32'd0);
    endtask

    // Plays the ALU side for one program run; the model walks the program list directly.
    task automatic run_prog(input int abort_at, input int tmo_at, input bit poke,
                            input bit new0, input logic [IW-1:0] w0);
        logic [IW-1:0] w;
        logic [2:0]    eop;
        logic [W-1:0]  ea, eb, r;
        bit            last;
        int            s, d;
        start = 1'b1;
        if (new0) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = w0;
            prog[0]   = w0;
        end
        step();
        start   = 1'b0;
        load_en = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_iv", 32'(issue_valid), 32'd0);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        for (int i = 0; i < D; i++) begin
            w    = prog[i];
            eop  = w[2:0];
            ea   = w[3] ? m_prev : w[4+2*W:5+W];
            eb   = w[4+W:5];
            last = w[4] || (i == D - 1);
            step();
            chk("iv_rise", 32'(issue_valid), 32'd1);
            chk("pc", 32'(pc), 32'(i));
            chk("payload", 32'({issue_op, issue_a, issue_b}), 32'({eop, ea, eb}));
            s = $urandom_range(0, 3);
            for (int j = 0; j < s; j++) begin
                issue_ready = 1'b0;
                res_valid   = 1'($urandom_range(0, 1));
                res_data    = W'($urandom);
                step();
                chk("hold_iv", 32'(issue_valid), 32'd1);
                chk("hold_pay", 32'({issue_op, issue_a, issue_b}), 32'({eop, ea, eb}));
            end
            issue_ready = 1'b1;
            step();
            issue_ready = 1'b0;
            res_valid   = 1'b0;
            chk("xfer_iv", 32'(issue_valid), 32'd0);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals("abort");
                m_prev = '0;
                step();
                rst_n = 1'b1;
                return;
            end
            if (i == tmo_at) begin
`ifdef SEQ_TIMEOUT_EN
                repeat (15) step();
                chk("tmo_early", 32'(done), 32'd0);
                step();
                chk("tmo_done", 32'(done), 32'd1);
                chk("tmo_err", 32'(err), 32'd1);
                chk("tmo_busy", 32'(busy), 32'd0);
                return;
`else
                repeat (20) step();
                chk("wait_busy", 32'(busy), 32'd1);
                chk("wait_done", 32'(done), 32'd0);
                chk("wait_err", 32'(err), 32'd0);
`endif
            end
            d = poke ? $urandom_range(1, 3) : $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                if (poke) begin
                    start     = 1'b1;
                    load_en   = 1'b1;
                    load_addr = AW'((i + 1) % D);
                    load_data = ~prog[(i + 1) % D];
                end
                step();
                start   = 1'b0;
                load_en = 1'b0;
            end
            r         = alu(eop, ea, eb);
            res_valid = 1'b1;
            res_data  = r;
            step();
            res_valid = 1'b0;
            m_prev    = r;
            if (last) begin
                chk("end_done", 32'(done), 32'd1);
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_pc", 32'(pc), 32'(i));
                chk("end_iv", 32'(issue_valid), 32'd0);
                res_valid = 1'b1;
                res_data  = W'($urandom);
                step();
                step();
                res_valid = 1'b0;
                chk("done_hold", 32'({done, busy, issue_valid, pc}), 32'({3'b100, AW'(i)}));
                return;
            end
            chk("mid_done", 32'(done), 32'd0);
            chk("mid_iv", 32'(issue_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        issue_ready = 1'b0; res_valid = 1'b0; res_data = '0; m_prev = '0;
        repeat (3) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();

        load_random(0);
        load_word(0, mk(3'd0, 1'b0, 1'b0, 4'd10, 4'd5));
        load_word(1, mk(3'd1, 1'b1, 1'b0, 4'd0, 4'd3));
        load_word(2, mk(3'd2, 1'b1, 1'b1, 4'd0, 4'd15));
        run_prog(-1, -1, 1'b0, 1'b0, '0);
        chk("directed_prev", 32'(m_prev), 32'd12);

        load_random(0);
        run_prog(-1, -1, 1'b1, 1'b0, '0);
        run_prog(1, -1, 1'b0, 1'b0, '0);
        run_prog(-1, -1, 1'b0, 1'b0, '0);

        run_prog(-1, 0, 1'b0, 1'b0, '0);
        run_prog(-1, -1, 1'b0, 1'b1, IW'($urandom));

        for (int t = 0; t < 6; t++) begin
            load_random(3);
            run_prog(-1, -1, t[0], t[1], IW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
